// File: rtl/reg_writeback.sv
// Register-file write-port writer: arbitrates ALU and load results into an in-order FIFO,
// drains one entry per cycle, and exports a pending-destination mask for hazard stalls.
module reg_writeback #(
  parameter int unsigned N        = 63,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [N:0]               alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [N:0]               mem_data,
  output logic                     RegWrite,
  output logic [4:0]               Write_register,
  output logic [N:0]               Write_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Storage is intentionally not reset; valid_q qualifies every read of it.
  logic [4:0]      rd_mem   [DEPTH];
  logic [N:0]      data_mem [DEPTH];
  logic            zero_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic            full, empty;
  logic            mem_push, alu_push, push, pop;
  logic [4:0]      push_rd;
  logic [N:0]      push_data;
  logic            push_zero;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Load has fixed priority; readiness looks at registered count only.
  assign mem_ready = rst_n & ~full;
  assign alu_ready = rst_n & ~full & ~mem_valid;

  assign mem_push  = mem_valid & mem_ready;
  assign alu_push  = alu_valid & alu_ready;
  assign push      = mem_push | alu_push;
  assign pop       = ~empty;

  assign push_rd   = mem_push ? mem_rd : alu_rd;
  assign push_data = mem_push ? mem_data : alu_data;
  assign push_zero = (push_rd == 5'(ZERO_REG));

  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= push_rd;
      data_mem[wr_ptr_q] <= push_data;
      zero_mem[wr_ptr_q] <= push_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      count_q <= count_d;
      if (pop) begin
        rd_ptr_q          <= rd_ptr_q + 1'b1;
        valid_q[rd_ptr_q] <= 1'b0;
      end
      // Push never targets the head slot while it pops, since push is blocked when full.
      if (push) begin
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        valid_q[wr_ptr_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !zero_mem[i]) begin
        pend_mask[rd_mem[i]] = 1'b1;
      end
    end
  end

  assign Write_register = rd_mem[rd_ptr_q];
  assign Write_data     = data_mem[rd_ptr_q];
  assign RegWrite       = ~empty & ~zero_mem[rd_ptr_q];
  assign occupancy      = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboarded bench for reg_writeback: driver queues expected writes, monitor checks the port.
module tb_reg_writeback;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [63:0] alu_data, mem_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [63:0] Write_data;
  logic [31:0] pend_mask;
  logic [2:0]  occupancy;

  reg_writeback #(.N(63), .DEPTH(DEPTH), .ZERO_REG(31)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data),
    .pend_mask      (pend_mask),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every write seen on the port must match the oldest expected entry.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write",
                 Write_register, Write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (Write_register !== e.rd || Write_data !== e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=%h expected rd=%0d data=%h",
                   Write_register, Write_data, e.rd, e.data);
        end
      end
    end
  end

  // One cycle of stimulus; the FIFO drains every cycle so it never fills,
  // hence mem is always ready and alu is ready exactly when mem is idle.
  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad);
    @(negedge clk);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    chk("mem_ready", 64'(mem_ready), 64'd1);
    chk("alu_ready", 64'(alu_ready), 64'(!mv));
    if (mv) begin
      if (mrd != 5'd31) exp_q.push_back('{rd: mrd, data: md});
    end else if (av) begin
      if (ard != 5'd31) exp_q.push_back('{rd: ard, data: ad});
    end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h11;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h22;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_pend_mask", 64'(pend_mask), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    mem_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    idle();
    chk("single_regwrite", 64'(RegWrite), 64'd1);
    chk("single_pend_mask", 64'(pend_mask), 64'h20);
    chk("single_occupancy", 64'(occupancy), 64'd1);
    idle();
    chk("single_clear_regwrite", 64'(RegWrite), 64'd0);
    chk("single_clear_pend", 64'(pend_mask), 64'd0);
    chk("single_clear_occ", 64'(occupancy), 64'd0);

    // Both valid: load first, ALU the following cycle
    drive(1'b1, 5'd3, 64'h3333, 1'b1, 5'd4, 64'h4444);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'h4444);
    chk("arb_first_rd", 64'(Write_register), 64'd3);
    idle();
    chk("arb_second_rd", 64'(Write_register), 64'd4);
    chk("arb_second_pend", 64'(pend_mask), 64'h10);
    idle();

    // Back-to-back loads
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(10 + i), 64'hA000 + 64'(i), 1'b0, 5'd0, 64'd0);
      chk("fill_occ_bound", 64'(occupancy <= DEPTH), 64'd1);
    end
    idle();
    chk("fill_last_rd", 64'(Write_register), 64'd14);
    idle();
    chk("fill_drained_occ", 64'(occupancy), 64'd0);

    // Zero register
    drive(1'b1, 5'd31, 64'hBAD, 1'b0, 5'd0, 64'd0);
    drive(1'b1, 5'd1, 64'h0101, 1'b0, 5'd0, 64'd0);
    chk("zero_regwrite", 64'(RegWrite), 64'd0);
    chk("zero_pend_mask", 64'(pend_mask), 64'd0);
    chk("zero_occupancy", 64'(occupancy), 64'd1);
    idle();
    chk("zero_next_regwrite", 64'(RegWrite), 64'd1);
    chk("zero_next_pend", 64'(pend_mask), 64'h2);
    idle();

    // Asynchronous reset with an entry queued and another being offered
    drive(1'b1, 5'd7, 64'h7777, 1'b0, 5'd0, 64'd0);
    drive(1'b1, 5'd8, 64'h8888, 1'b0, 5'd0, 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_occupancy", 64'(occupancy), 64'd0);
    chk("async_regwrite", 64'(RegWrite), 64'd0);
    chk("async_pend_mask", 64'(pend_mask), 64'd0);
    chk("async_mem_ready", 64'(mem_ready), 64'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    chk("async_post_occ", 64'(occupancy), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
